// File: rtl/ds_pkg.sv
// Shared types and constants for the delta-sigma decimation sequencer.
package ds_pkg;
  localparam int DS_W       = 20;
  localparam int DS_CNTW    = 16;
  localparam int SETTLE_DEF = 3;
  localparam int OSR_MIN    = 4;

  typedef enum logic [1:0] {DS_IDLE, DS_SETTLE, DS_RUN} ds_state_e;
endpackage

// File: rtl/ds_clkdiv.sv
// Decimation clock divider. The div counter runs 0..osr_eff-1 while run is high.
// dclk rises as div wraps and falls at mid-period. strobe marks the mid-point of
// each dclk period, but only after the first dclk rise (the armed flag).
module ds_clkdiv import ds_pkg::*; #(
  parameter int CNTW = DS_CNTW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [CNTW-1:0] osr_eff,
  output logic            dclk,
  output logic            strobe
);
  logic [CNTW-1:0] div;
  logic [CNTW-1:0] half;
  logic [CNTW-1:0] last;
  logic            armed;

  assign half   = osr_eff >> 1;
  assign last   = osr_eff - CNTW'(1);
  assign strobe = armed && (div == half);

  // Divider, dclk and armed flag; everything is held at zero while not running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      dclk  <= 1'b0;
      armed <= 1'b0;
    end else if (!run) begin
      div   <= '0;
      dclk  <= 1'b0;
      armed <= 1'b0;
    end else begin
      div <= (div == last) ? '0 : div + CNTW'(1);
      if (div == last) begin
        dclk  <= 1'b1;
        armed <= 1'b1;
      end else if (div == half - CNTW'(1)) begin
        dclk  <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/ds_decim_ctrl.sv
// Sequencer for the sinc3 decimation filter: drives dclk and the filter reset,
// discards the unsettled first outputs and presents samples on a valid/ready port.
// Optional macro DS_OVR_CNT_EN: enables the 8-bit saturating dropped-sample counter
// on ovr_cnt; without it ovr_cnt is tied to zero.
module ds_decim_ctrl import ds_pkg::*; #(
  parameter int W      = DS_W,
  parameter int CNTW   = DS_CNTW,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [CNTW-1:0] osr,
  input  logic [W-1:0]    filt_data,
  output logic            dclk,
  output logic            filt_rst_n,
  output logic [W-1:0]    m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            busy,
  output logic            overrun,
  output logic [7:0]      ovr_cnt
);
  localparam int SCW = $clog2(SETTLE + 1);

  ds_state_e       state;
  logic [CNTW-1:0] osr_eff;
  logic [SCW-1:0]  scnt;
  logic            run;
  logic            strobe;
  logic            start;
  logic            drop;

  // Divider runs only while active and still enabled, so it clears the cycle en drops.
  assign run   = (state != DS_IDLE) && en;
  assign start = (state == DS_IDLE) && en;
  assign drop  = (state == DS_RUN) && en && strobe && m_valid && !m_ready;

  ds_clkdiv #(.CNTW(CNTW)) u_clkdiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .osr_eff (osr_eff),
    .dclk    (dclk),
    .strobe  (strobe)
  );

  // Main FSM with registered outputs: start-up, settle discard, sample hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DS_IDLE;
      osr_eff    <= CNTW'(OSR_MIN);
      scnt       <= '0;
      filt_rst_n <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else if (start) begin
      state   <= DS_SETTLE;
      osr_eff <= (osr < CNTW'(OSR_MIN)) ? CNTW'(OSR_MIN) : osr;
      scnt    <= '0;
      busy    <= 1'b1;
      overrun <= 1'b0;
    end else if (state != DS_IDLE && !en) begin
      // Abort: any pending sample is lost and the filter goes back into reset.
      state      <= DS_IDLE;
      busy       <= 1'b0;
      m_valid    <= 1'b0;
      filt_rst_n <= 1'b0;
    end else if (state == DS_SETTLE) begin
      filt_rst_n <= 1'b1;
      if (strobe) begin
        if (scnt == SCW'(SETTLE - 1)) state <= DS_RUN;
        else                          scnt  <= scnt + SCW'(1);
      end
    end else if (state == DS_RUN) begin
      filt_rst_n <= 1'b1;
      if (strobe) begin
        if (!m_valid || m_ready) begin
          m_data  <= filt_data;
          m_valid <= 1'b1;
        end
        if (drop) overrun <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef DS_OVR_CNT_EN
  logic [7:0] ovr_cnt_q;

  // Saturating dropped-sample counter, cleared only when a new run starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ovr_cnt_q <= '0;
    else if (start)                      ovr_cnt_q <= '0;
    else if (drop && ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
  end

  assign ovr_cnt = ovr_cnt_q;
`else
  assign ovr_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_ds_decim_ctrl.sv
// Bench for ds_decim_ctrl: cycle-level behavioural model (time since start,
// modular arithmetic on osr_eff) compared every cycle, plus directed literal checks.
module tb_ds_decim_ctrl;
  localparam int W = 20;
  localparam int CNTW = 16;
  localparam int SETTLE = 3;
  localparam logic [W-1:0] BASE = 20'h1000;
`ifdef DS_OVR_CNT_EN
  localparam int EXP_CNT3 = 3;
`else
  localparam int EXP_CNT3 = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [CNTW-1:0] osr;
  logic [W-1:0]    filt_data;
  logic            dclk, filt_rst_n, m_valid, m_ready, busy, overrun;
  logic [W-1:0]    m_data;
  logic [7:0]      ovr_cnt;

  int checks = 0;
  int failures = 0;

  ds_decim_ctrl #(.W(W), .CNTW(CNTW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .osr(osr), .filt_data(filt_data),
    .dclk(dclk), .filt_rst_n(filt_rst_n), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .overrun(overrun), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: t = cycles since the run started.
  bit         act_m;
  int         t, oe, hf, ocnt;
  bit         mv, ovr;
  logic [W-1:0] md;

  always @(posedge clk) begin
    if (!rst_n) begin
      act_m = 0; t = 0; oe = 4; hf = 2; mv = 0; md = '0; ovr = 0; ocnt = 0;
    end else if (!act_m) begin
      if (en) begin
        act_m = 1; t = 0; oe = (int'(osr) < 4) ? 4 : int'(osr); hf = oe / 2;
        ovr = 0; ocnt = 0;
      end
    end else if (!en) begin
      act_m = 0; mv = 0;
    end else begin
      if (t >= oe && (t % oe) == hf && (t / oe) > SETTLE) begin
        if (!mv || m_ready) begin mv = 1; md = filt_data; end
        else begin ovr = 1; if (ocnt < 255) ocnt++; end
      end else if (mv && m_ready) begin
        mv = 0;
      end
      t++;
    end
    #1;
    chk("busy", busy, act_m);
    chk("dclk", dclk, act_m && t >= oe && (t % oe) < hf);
    chk("filt_rst_n", filt_rst_n, act_m && t >= 1);
    chk("m_valid", m_valid, mv);
    if (mv) chk("m_data", m_data, md);
    chk("overrun", overrun, ovr);
`ifdef DS_OVR_CNT_EN
    chk("ovr_cnt", ovr_cnt, ocnt);
`else
    chk("ovr_cnt", ovr_cnt, 0);
`endif
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dclk"}, dclk, 0);
    chk({tag, "_filt_rst_n"}, filt_rst_n, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_ovr_cnt"}, ovr_cnt, 0);
  endtask

  // One directed run, entered and left at a negedge; en is raised on entry.
  task automatic run_seq(input int scn, input logic [CNTW-1:0] osr_v, input int ncyc);
    int fr = -1;
    int fv = -1;
    osr = osr_v; en = 1; filt_data = BASE - 1;
    m_ready = (scn == 2 || scn == 6);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #2;
      if (dclk && fr < 0) fr = c;
      if (m_valid && fv < 0) fv = c;
      if (scn == 1 && c == 11) chk("s1_dclk_hi_end", dclk, 1);
      if (scn == 1 && c == 12) chk("s1_dclk_lo", dclk, 0);
      if (scn == 1 && c == 37) chk("s1_first_data", m_data, BASE + 36);
      if (scn == 1 && c == 61) begin
        chk("s3_m_data_held", m_data, BASE + 36);
        chk("s3_m_valid", m_valid, 1);
        chk("s3_overrun", overrun, 1);
        chk("s3_ovr_cnt", ovr_cnt, EXP_CNT3);
      end
      if (scn == 4 && c == 1) begin
        chk("s5_overrun_cleared", overrun, 0);
        chk("s5_ovr_cnt_cleared", ovr_cnt, 0);
      end
      if (scn == 4 && c == 45) begin
        chk("s4_m_valid", m_valid, 1);
        chk("s4_m_data_new", m_data, BASE + 44);
        chk("s4_overrun", overrun, 0);
      end
      if (scn == 4 && c == 56) chk("s6_dclk_hi", dclk, 1);
      if (scn == 4 && c == 60) chk("s6_dclk_lo", dclk, 0);
      @(negedge clk);
      filt_data = BASE + W'(c);
      if (scn == 4) m_ready = (c == 44);
      if (scn == 4 && c >= 50) osr = 16;
    end
    if (scn == 1 || scn == 4) begin
      chk("first_rise_osr8", fr, 8);
      chk("first_valid_osr8", fv, 37);
    end
    if (scn == 2) begin
      chk("first_rise_osr2", fr, 4);
      chk("first_valid_osr2", fv, 19);
    end
  endtask

  task automatic stop_run(input string tag);
    en = 0;
    @(posedge clk); #2;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_filt_rst_n"}, filt_rst_n, 0);
    chk({tag, "_dclk"}, dclk, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 0; en = 0; osr = 8; m_ready = 0; filt_data = '0;
    #3;
    chk_reset_vals("por");
    #17;
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    run_seq(1, 16'd8, 70);
    stop_run("s5_abort");
    chk("s5_overrun_sticky_idle", overrun, 1);
    run_seq(4, 16'd8, 70);
    stop_run("s4_stop");
    run_seq(2, 16'd2, 30);
    stop_run("s2_stop");
    run_seq(6, 16'd8, 10);
    rst_n = 0; #1;
    chk_reset_vals("s6_midsettle_rst");
    @(negedge clk); rst_n = 1;

    // Randomized phase; osr changes every cycle but only start-time values matter.
    for (int seg = 0; seg < 8; seg++) begin
      int rp = $urandom_range(1, 4);
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        en        = ($urandom_range(0, 249) != 0);
        osr       = 16'($urandom_range(0, 20));
        m_ready   = ($urandom_range(0, 4) < rp);
        filt_data = 20'($urandom());
      end
    end
    @(negedge clk); en = 0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
